ram_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller that drives the dual-port block RAM memory (w_en/w_addr/w_data,
//  r_en/r_addr/r_data, 1-cycle registered read) and turns it into a streaming FIFO.

---
 rtl/ram_fifo_ctrl_if.sv | 36 +++
 rtl/ram_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the push/pop streaming handshakes and the block-RAM port for ram_fifo_ctrl.
//   in_*        push side (producer -> controller)
//   out_*       pop side (controller -> consumer), plus occupancy count
//   mem_w_*     RAM write port (controller -> RAM)
//   mem_r_*     RAM read port; mem_r_data returns the cycle after mem_r_en
// Modports: slave = the controller, master = the surrounding producer/consumer/RAM.
interface ram_fifo_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH+1:0] count;
   logic                  mem_w_en;
   logic [ADDR_WIDTH-1:0] mem_w_addr;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic                  mem_r_en;
   logic [ADDR_WIDTH-1:0] mem_r_addr;
   logic [DATA_WIDTH-1:0] mem_r_data;

   modport slave (
      input  in_data, in_valid, out_ready, mem_r_data,
      output in_ready, out_data, out_valid, count,
             mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
   );

   modport master (
      output in_data, in_valid, out_ready, mem_r_data,
      input  in_ready, out_data, out_valid, count,
             mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller in front of a dual-port block RAM with 1-cycle registered read.
// Generates RAM write/read addresses and enables and absorbs read data into a 2-entry
// skid buffer so a word can leave every cycle.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         ram_fifo_ctrl_if.slave: push handshake, pop handshake + count, RAM ports
module ram_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   ram_fifo_ctrl_if.slave bus
);
   localparam int unsigned PW = ADDR_WIDTH + 1;
   localparam int unsigned CW = ADDR_WIDTH + 2;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [1:0]            skid_cnt_q, skid_cnt_d;
   logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
   logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
   logic [CW-1:0]         count_q, count_d;

   logic [PW-1:0] mem_cnt;
   logic [PW-1:0] mem_cnt_nxt;
   logic          full;
   logic          push;
   logic          pop;
   logic          issue;
   logic          out_valid_c;
   logic [2:0]    occ;

   // Handshake decode; push is masked in reset so no RAM write can slip through.
   always_comb begin
      mem_cnt     = wr_ptr_q - rd_ptr_q;
      full        = (mem_cnt == DEPTH);
      push        = bus.in_valid & ~full & rst_n;
      out_valid_c = (skid_cnt_q != 2'd0);
      pop         = out_valid_c & bus.out_ready;
      // Words already owed to the skid after this edge: held + in flight - leaving.
      occ         = 3'(skid_cnt_q) + 3'(rd_pend_q);
      issue       = (mem_cnt != '0) & (occ < (3'd2 + 3'(pop)));
   end

   // Next-state for pointers, read-pending flag, skid buffer and occupancy count.
   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(issue);
      rd_pend_d  = issue;
      skid_cnt_d = skid_cnt_q;
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;

      // skid0 is always the head; a capture fills the first free slot after any pop.
      case ({rd_pend_q, pop})
         2'b01: begin
            skid0_d    = skid1_q;
            skid_cnt_d = skid_cnt_q - 2'd1;
         end
         2'b10: begin
            if (skid_cnt_q == 2'd0) begin
               skid0_d = bus.mem_r_data;
            end else begin
               skid1_d = bus.mem_r_data;
            end
            skid_cnt_d = skid_cnt_q + 2'd1;
         end
         2'b11: begin
            if (skid_cnt_q == 2'd1) begin
               skid0_d = bus.mem_r_data;
            end else begin
               skid0_d = skid1_q;
               skid1_d = bus.mem_r_data;
            end
         end
         default: ;
      endcase

      // Difference taken at pointer width first so the mod-2**PW wrap is preserved.
      mem_cnt_nxt = wr_ptr_d - rd_ptr_d;
      count_d     = CW'(mem_cnt_nxt) + CW'(rd_pend_d) + CW'(skid_cnt_d);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_pend_q  <= 1'b0;
         skid_cnt_q <= 2'd0;
         skid0_q    <= '0;
         skid1_q    <= '0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_pend_q  <= rd_pend_d;
         skid_cnt_q <= skid_cnt_d;
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
         count_q    <= count_d;
      end
   end

   // Output drive.
   assign bus.in_ready   = ~full;
   assign bus.out_data   = skid0_q;
   assign bus.out_valid  = out_valid_c;
   assign bus.count      = count_q;
   assign bus.mem_w_en   = push;
   assign bus.mem_w_addr = wr_ptr_q[ADDR_WIDTH-1:0];
   assign bus.mem_w_data = bus.in_data;
   assign bus.mem_r_en   = issue;
   assign bus.mem_r_addr = rd_ptr_q[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural dual-port RAM (1-cycle registered read).
module tb_ram_fifo_ctrl;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Block RAM model.
   logic [DW-1:0] ram [2**AW];
   logic [DW-1:0] ram_rdata;
   always_ff @(posedge clk) begin
      if (bus.mem_w_en) ram[bus.mem_w_addr] <= bus.mem_w_data;
      if (bus.mem_r_en) ram_rdata <= ram[bus.mem_r_addr];
   end
   assign bus.mem_r_data = ram_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge; caller samples 1 ns later.
   task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
   endtask

   initial begin
      logic [DW-1:0] q[$];
      logic [DW-1:0] d;
      logic          iv;
      logic          ordy;
      int            pushed;
      int            max_cnt;
      int            w_wraps;
      int            r_wraps;
      logic [AW-1:0] last_w;
      logic [AW-1:0] last_r;

      n_tests = 0;
      n_fail  = 0;

      // 1: reset, with a push request held to prove it is masked.
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hFF;
      bus.out_ready = 1'b0;
      #3;
      check_eq("rst_out_valid", 32'(bus.out_valid), 0);
      check_eq("rst_count",     32'(bus.count),     0);
      check_eq("rst_in_ready",  32'(bus.in_ready),  1);
      check_eq("rst_mem_w_en",  32'(bus.mem_w_en),  0);
      check_eq("rst_mem_r_en",  32'(bus.mem_r_en),  0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_count_hold", 32'(bus.count), 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;

      // 2: single word latency.
      drive(1'b1, 8'hA5, 1'b1);
      check_eq("single_w_en",   32'(bus.mem_w_en),   1);
      check_eq("single_w_addr", 32'(bus.mem_w_addr), 0);
      check_eq("single_r_en0",  32'(bus.mem_r_en),   0);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("single_r_en1",  32'(bus.mem_r_en),   1);
      check_eq("single_r_addr", 32'(bus.mem_r_addr), 0);
      check_eq("single_count1", 32'(bus.count),      1);
      check_eq("single_ov1",    32'(bus.out_valid),  0);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("single_ov2",    32'(bus.out_valid),  0);
      check_eq("single_count2", 32'(bus.count),      1);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("single_ov3",    32'(bus.out_valid),  1);
      check_eq("single_data",   32'(bus.out_data),   32'h A5);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("single_ov4",    32'(bus.out_valid),  0);
      check_eq("single_count4", 32'(bus.count),      0);

      // 3: fill to capacity with the consumer stalled, then drain.
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         check_eq("fill_in_ready", 32'(bus.in_ready), 1);
      end
      drive(1'b1, 8'h12, 1'b0);
      check_eq("full_in_ready", 32'(bus.in_ready), 0);
      check_eq("full_w_en",     32'(bus.mem_w_en), 0);
      check_eq("full_count",    32'(bus.count),    18);
      check_eq("full_head",     32'(bus.out_data), 0);
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         check_eq("drain_valid", 32'(bus.out_valid), 1);
         check_eq("drain_data",  32'(bus.out_data),  32'(i));
      end
      drive(1'b0, 8'h00, 1'b1);
      check_eq("drain_empty_valid", 32'(bus.out_valid), 0);
      check_eq("drain_empty_count", 32'(bus.count),     0);

      // 4: sustained streaming, one word per cycle once primed.
      for (int t = 0; t < 44; t++) begin
         drive(t < 40, 8'(t), 1'b1);
         check_eq("stream_valid", 32'(bus.out_valid), 32'((t >= 3) && (t < 43)));
         if (t >= 3 && t < 43) check_eq("stream_data", 32'(bus.out_data), 32'(t - 3));
      end
      check_eq("stream_count_end", 32'(bus.count), 0);

      // 5: random valid/ready against a queue scoreboard, including full periods.
      pushed  = 0;
      max_cnt = 0;
      w_wraps = 0;
      r_wraps = 0;
      last_w  = '0;
      last_r  = '0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (pushed == 200 && q.size() == 0) break;
         iv   = (pushed < 200) && ($urandom_range(99) < 60);
         ordy = (cyc < 120) ? ($urandom_range(99) < 25) : ($urandom_range(99) < 65);
         d    = 8'(pushed * 13 + 5);
         drive(iv, d, ordy);
         check_eq("rnd_count", 32'(bus.count), 32'(q.size()));
         if (bus.out_valid) begin
            if (q.size() == 0) check_eq("rnd_spurious", 1, 0);
            else               check_eq("rnd_data", 32'(bus.out_data), 32'(q[0]));
         end
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
         if (bus.mem_w_en) begin
            if (last_w == 4'd15 && bus.mem_w_addr == 4'd0) w_wraps++;
            last_w = bus.mem_w_addr;
         end
         if (bus.mem_r_en) begin
            if (last_r == 4'd15 && bus.mem_r_addr == 4'd0) r_wraps++;
            last_r = bus.mem_r_addr;
         end
         if (bus.out_valid && ordy && q.size() > 0) void'(q.pop_front());
         if (iv && bus.in_ready) begin
            q.push_back(d);
            pushed++;
         end
      end
      check_eq("rnd_all_pushed", 32'(pushed),            200);
      check_eq("rnd_drained",    32'(q.size()),          0);
      check_eq("rnd_max_le_18",  32'(max_cnt <= 18),     1);
      check_eq("rnd_hit_full",   32'(max_cnt),           18);
      check_eq("rnd_w_wraps",    32'(w_wraps >= 10),     1);
      check_eq("rnd_r_wraps",    32'(r_wraps >= 10),     1);

      // 6: asynchronous reset mid-stream, then a clean restart.
      for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check_eq("pre_rst_count", 32'(bus.count), 7);
      bus.in_valid = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", 32'(bus.out_valid), 0);
      check_eq("arst_count",     32'(bus.count),     0);
      check_eq("arst_in_ready",  32'(bus.in_ready),  1);
      check_eq("arst_w_en",      32'(bus.mem_w_en),  0);
      check_eq("arst_r_en",      32'(bus.mem_r_en),  0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      drive(1'b1, 8'h3C, 1'b1);
      check_eq("post_w_addr", 32'(bus.mem_w_addr), 0);
      check_eq("post_ov0",    32'(bus.out_valid),  0);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("post_ov1",    32'(bus.out_valid),  0);
      check_eq("post_r_en",   32'(bus.mem_r_en),   1);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("post_ov2",    32'(bus.out_valid),  0);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("post_ov3",    32'(bus.out_valid),  1);
      check_eq("post_data",   32'(bus.out_data),   32'h3C);
      drive(1'b0, 8'h00, 1'b1);
      check_eq("post_ov4",    32'(bus.out_valid),  0);
      check_eq("post_count",  32'(bus.count),      0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
